// File: rtl/img_proc_pkg.sv
// Shared image-processing definitions: default geometry and the line feeder FSM state type.
package img_proc_pkg;

  localparam int unsigned DefaultDataWidth  = 8;
  localparam int unsigned DefaultImgWidth   = 512;
  localparam int unsigned DefaultImgHeight  = 512;
  localparam int unsigned DefaultNumBuffers = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StDone
  } feederState_e;

endpackage

// File: rtl/line_feeder.sv
// Line feeder: streams one frame of pixels into a downstream line-buffered stage, gated by
// a credit count of free downstream line buffers.
// Optional feature: define LINE_FEEDER_PAD_EN to wrap the frame in one all-zero pad line
// before the first and after the last image line.
module line_feeder
  import img_proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned IMG_WIDTH   = DefaultImgWidth,
  parameter int unsigned IMG_HEIGHT  = DefaultImgHeight,
  parameter int unsigned NUM_BUFFERS = DefaultNumBuffers
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] sData,
  input  logic                  sValid,
  output logic                  sReady,
  output logic [DATA_WIDTH-1:0] outPixel,
  output logic                  outPixelValid,
  input  logic                  rdBuffEmpty,
  output logic                  busy,
  output logic                  frameDone
);

  localparam int unsigned CreditW = $clog2(NUM_BUFFERS + 1);
  localparam int unsigned ColW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned LineW   = $clog2(IMG_HEIGHT + 2);
`ifdef LINE_FEEDER_PAD_EN
  localparam int unsigned TotalLines = IMG_HEIGHT + 2;
`else
  localparam int unsigned TotalLines = IMG_HEIGHT;
`endif

  localparam logic [CreditW-1:0] CreditMax = CreditW'(NUM_BUFFERS);
  localparam logic [ColW-1:0]    ColLast   = ColW'(IMG_WIDTH - 1);
  localparam logic [LineW-1:0]   LineLast  = LineW'(TotalLines - 1);

  feederState_e stateQ, stateD;

  logic [CreditW-1:0]    creditQ, creditD;
  logic [ColW-1:0]       colQ, colD;
  logic [LineW-1:0]      lineQ, lineD;
  logic                  xfer;
  logic                  endOfLine;
  logic                  lastLine;
  logic                  creditInc;
  logic [DATA_WIDTH-1:0] pixelSel;

`ifdef LINE_FEEDER_PAD_EN
  logic padLine;
  assign padLine = (lineQ == '0) || (lineQ == LineLast);
`endif

  // Transfer qualification and the pixel that a transfer would capture.
  always_comb begin
`ifdef LINE_FEEDER_PAD_EN
    // Pad lines run one pixel per cycle without consuming upstream data.
    xfer     = (stateQ == StSend) && (padLine || sValid);
    pixelSel = padLine ? '0 : sData;
`else
    xfer     = sValid && sReady;
    pixelSel = sData;
`endif
    endOfLine = xfer && (colQ == ColLast);
    lastLine  = (lineQ == LineLast);
    creditInc = rdBuffEmpty && ((stateQ == StSend) || (stateQ == StWait));
  end

  // Next values of the column, line and credit counters.
  always_comb begin
    creditD = creditQ;
    colD    = colQ;
    lineD   = lineQ;
    if ((stateQ == StIdle) && start) begin
      creditD = CreditMax;
      colD    = '0;
      lineD   = '0;
    end else begin
      if (xfer) begin
        colD = endOfLine ? '0 : colQ + ColW'(1);
      end
      if (endOfLine) begin
        lineD = lineQ + LineW'(1);
      end
      // A freed buffer arriving with the end-of-line consume cancels out.
      if (endOfLine && !creditInc) begin
        creditD = creditQ - CreditW'(1);
      end else if (creditInc && !endOfLine && (creditQ != CreditMax)) begin
        creditD = creditQ + CreditW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      creditQ <= '0;
      colQ    <= '0;
      lineQ   <= '0;
    end else begin
      creditQ <= creditD;
      colQ    <= colD;
      lineQ   <= lineD;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          stateD = StSend;
        end
      end
      StSend: begin
        if (endOfLine) begin
          if (lastLine) begin
            stateD = StDone;
          end else if (creditD == '0) begin
            stateD = StWait;
          end
        end
      end
      StWait: begin
        if (creditQ != '0) begin
          stateD = StSend;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
`ifdef LINE_FEEDER_PAD_EN
    sReady = (stateQ == StSend) && !padLine;
`else
    sReady = (stateQ == StSend);
`endif
    busy      = (stateQ != StIdle);
    frameDone = (stateQ == StDone);
  end

  // Output pixel register: one cycle of latency, holds its value between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outPixel      <= '0;
      outPixelValid <= 1'b0;
    end else begin
      outPixelValid <= xfer;
      if (xfer) begin
        outPixel <= pixelSel;
      end
    end
  end

endmodule

// File: doc/line_feeder.md
LINE_FEEDER -- requirements
Module: line_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 512, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 512, image lines per frame.
REQ-004 SHALL have parameter NUM_BUFFERS, default 4, line buffers in the downstream edge-detection stage.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (async assert, active-low).
REQ-006 SHALL have port start, input, 1 bit: frame start pulse.
REQ-007 SHALL have port sData, input, DATA_WIDTH bits: upstream pixel.
REQ-008 SHALL have port sValid, input, 1 bit: upstream pixel valid.
REQ-009 SHALL have port sReady, output, 1 bit: feeder accepts the upstream pixel this cycle.
REQ-010 SHALL have port outPixel, output, DATA_WIDTH bits: pixel to the edge-detection stage.
REQ-011 SHALL have port outPixelValid, output, 1 bit: outPixel valid (no backpressure downstream).
REQ-012 SHALL have port rdBuffEmpty, input, 1 bit: one-cycle pulse, downstream freed one line buffer.
REQ-013 SHALL have ports busy (output, 1 bit: frame in progress) and frameDone (output, 1 bit: one-cycle pulse after the last pixel).

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT, DONE.
REQ-015 IDLE: on start, SHALL load credit = NUM_BUFFERS, column = 0, line = 0, then go to SEND. start outside IDLE SHALL be ignored.
REQ-016 SHALL drive sReady = 1 only in SEND (combinational from state); a transfer occurs when sValid && sReady.
REQ-017 On a transfer, SHALL register outPixel <= sData and drive outPixelValid = 1 next cycle (latency 1); otherwise outPixelValid = 0 and outPixel holds.
REQ-018 SHALL increment the column counter per transfer and wrap it at IMG_WIDTH-1 -> 0, incrementing the line counter and decrementing credit.
REQ-019 At end of line: if line+1 == IMG_HEIGHT, SHALL go to DONE; else if resulting credit == 0, SHALL go to WAIT; else SHALL stay in SEND.
REQ-020 rdBuffEmpty in SEND/WAIT SHALL increment credit, saturating at NUM_BUFFERS. In IDLE/DONE it SHALL be ignored.
REQ-021 If rdBuffEmpty coincides with the end-of-line decrement, credit SHALL be unchanged and the FSM SHALL stay in SEND.
REQ-022 WAIT SHALL go to SEND in the cycle after credit becomes nonzero.
REQ-023 DONE SHALL last one cycle with frameDone = 1 and SHALL then return to IDLE.
REQ-024 busy SHALL be 1 in SEND, WAIT, and DONE.
REQ-025 Credit SHALL be $clog2(NUM_BUFFERS+1) bits wide, column $clog2(IMG_WIDTH), and line $clog2(IMG_HEIGHT+2).

Reset
REQ-026 On rst_n low, SHALL force state = IDLE, counters = 0, outPixel = 0, outPixelValid = 0, sReady = 0, busy = 0, frameDone = 0, immediately and asynchronously.
REQ-027 Reset mid-frame SHALL abandon the frame with no further outputs; a new start is required after release.

Configuration
REQ-028 With macro LINE_FEEDER_PAD_EN defined, SHALL emit one all-zero pad line before image line 0 and one after line IMG_HEIGHT-1 (IMG_HEIGHT+2 lines total).
REQ-029 Pad pixels SHALL be credit-gated like image lines, emitted one per cycle, with sReady = 0 throughout.
REQ-030 Without LINE_FEEDER_PAD_EN, SHALL emit exactly IMG_HEIGHT lines with no pad logic present.

Structure
REQ-031 SHALL place the FSM state enum and default DATA_WIDTH/IMG_WIDTH/IMG_HEIGHT/NUM_BUFFERS constants in shared package img_proc_pkg.
REQ-032 SHALL have no sub-module. Credit tracking SHALL be the single natural split point if factored, as credit_counter.

Verification
(Use IMG_WIDTH=4, IMG_HEIGHT=6, NUM_BUFFERS=4.)
REQ-033 start, sValid held 1, no rdBuffEmpty -> exactly 16 pixels out, then WAIT with sReady = 0 indefinitely.
REQ-034 From WAIT, one rdBuffEmpty pulse -> exactly 4 more pixels, then WAIT again; after 2 pulses total the frame ends, frameDone = 1 for one cycle, and busy drops next cycle.
REQ-035 rdBuffEmpty on the same cycle as the 4th pixel of a line with credit = 1 -> no WAIT entry and continuous output.
REQ-036 sValid toggling 1/0 -> outPixelValid mirrors accepted transfers one cycle later, and data order is preserved (ramp 0..23).
REQ-037 rst_n low after 10 pixels -> outputs zero asynchronously; start after release restarts from line 0 with credit 4.
REQ-038 With LINE_FEEDER_PAD_EN: 4 zeros, then 12 image pixels, then WAIT; full frame = 32 pixels, with the first 4 and last 4 zero.
